// File: rtl/shift_unit.sv
// Multi-mode shift register. A parallel load or a shift/rotate command is
// accepted while idle; a command then advances one position per enabled cycle
// and signals completion with a one-cycle done pulse.
module shift_unit #(
  parameter int   p_nbits       = 8,
  parameter logic p_reset_value = 1'b0,
  parameter int   p_amt_w       = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [p_nbits-1:0] load,
  input  logic               load_en,
  input  logic               start,
  input  logic [2:0]         op,
  input  logic [p_amt_w-1:0] amount,
  input  logic               d,
  input  logic               en,
  output logic [p_nbits-1:0] q,
  output logic               so,
  output logic               busy,
  output logic               done
);

  localparam logic [2:0] c_op_sll = 3'b000;
  localparam logic [2:0] c_op_srl = 3'b001;
  localparam logic [2:0] c_op_sra = 3'b010;
  localparam logic [2:0] c_op_rol = 3'b011;
  localparam logic [2:0] c_op_ror = 3'b100;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t               r_state;
  logic [p_nbits-1:0]   r_q;
  logic                 r_so;
  logic                 r_done;
  logic [2:0]           r_op;
  logic [p_amt_w-1:0]   r_cnt;

  state_t               w_state_next;
  logic [p_nbits-1:0]   w_q_next;
  logic                 w_so_next;
  logic                 w_done_next;
  logic [2:0]           w_op_next;
  logic [p_amt_w-1:0]   w_cnt_next;

  logic [p_nbits-1:0]   w_pos_q;
  logic                 w_pos_so;

  // Result of a single position of the latched operation applied to q.
  // Reserved opcodes leave q and so untouched.
  always_comb begin
    w_pos_q  = r_q;
    w_pos_so = r_so;
    case (r_op)
      c_op_sll: begin
        w_pos_q  = {r_q[p_nbits-2:0], d};
        w_pos_so = r_q[p_nbits-1];
      end
      c_op_srl: begin
        w_pos_q  = {d, r_q[p_nbits-1:1]};
        w_pos_so = r_q[0];
      end
      c_op_sra: begin
        w_pos_q  = {r_q[p_nbits-1], r_q[p_nbits-1:1]};
        w_pos_so = r_q[0];
      end
      c_op_rol: begin
        w_pos_q  = {r_q[p_nbits-2:0], r_q[p_nbits-1]};
        w_pos_so = r_q[p_nbits-1];
      end
      c_op_ror: begin
        w_pos_q  = {r_q[0], r_q[p_nbits-1:1]};
        w_pos_so = r_q[0];
      end
      default: begin
        w_pos_q  = r_q;
        w_pos_so = r_so;
      end
    endcase
  end

  // Next-state logic: load/start arbitration in IDLE, stepping in SHIFT.
  // done defaults low so it only lasts one cycle after being set.
  always_comb begin
    w_state_next = r_state;
    w_q_next     = r_q;
    w_so_next    = r_so;
    w_done_next  = 1'b0;
    w_op_next    = r_op;
    w_cnt_next   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (load_en) begin
          w_q_next = load;
        end else if (start) begin
          if (amount == '0) begin
            w_done_next = 1'b1;
          end else begin
            w_op_next    = op;
            w_cnt_next   = amount;
            w_state_next = S_SHIFT;
          end
        end
      end
      S_SHIFT: begin
        if (en) begin
          w_q_next   = w_pos_q;
          w_so_next  = w_pos_so;
          w_cnt_next = r_cnt - 1'b1;
          if (r_cnt == p_amt_w'(1)) begin
            w_state_next = S_IDLE;
            w_done_next  = 1'b1;
          end
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any command without a done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_q     <= {p_nbits{p_reset_value}};
      r_so    <= 1'b0;
      r_done  <= 1'b0;
      r_op    <= c_op_sll;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_q     <= w_q_next;
      r_so    <= w_so_next;
      r_done  <= w_done_next;
      r_op    <= w_op_next;
      r_cnt   <= w_cnt_next;
    end
  end

  assign q    = r_q;
  assign so   = r_so;
  assign busy = (r_state == S_SHIFT);
  assign done = r_done;

endmodule

// File: tb/tb_shift_unit.sv
// Self-checking bench for shift_unit: directed scenarios followed by random
// commands, compared against an arithmetic model of the register.
module tb_shift_unit;

  localparam int N    = 8;
  localparam int AW   = 4;
  localparam int FULL = 2 ** N;
  localparam int HALF = 2 ** (N - 1);

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  load;
  logic          load_en;
  logic          start;
  logic [2:0]    op;
  logic [AW-1:0] amount;
  logic          d;
  logic          en;
  logic [N-1:0]  q;
  logic          so;
  logic          busy;
  logic          done;

  int errors = 0;
  int checks = 0;
  int m_q;
  int m_so;

  shift_unit #(
    .p_nbits      (N),
    .p_reset_value(1'b1),
    .p_amt_w      (AW)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .load   (load),
    .load_en(load_en),
    .start  (start),
    .op     (op),
    .amount (amount),
    .d      (d),
    .en     (en),
    .q      (q),
    .so     (so),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // One position of an operation, expressed as integer arithmetic on the value.
  function automatic void model_pos(input int o, input int dv);
    int old_q;
    old_q = m_q;
    case (o)
      0: begin m_so = old_q / HALF; m_q = (old_q * 2 + dv) % FULL; end
      1: begin m_so = old_q % 2;    m_q = old_q / 2 + dv * HALF; end
      2: begin m_so = old_q % 2;    m_q = old_q / 2 + ((old_q >= HALF) ? HALF : 0); end
      3: begin m_so = old_q / HALF; m_q = (old_q * 2) % FULL + old_q / HALF; end
      4: begin m_so = old_q % 2;    m_q = old_q / 2 + (old_q % 2) * HALF; end
      default: ;
    endcase
  endfunction

  task automatic do_load(input logic [N-1:0] v);
    load    = v;
    load_en = 1'b1;
    start   = 1'b0;
    tick();
    load_en = 1'b0;
    m_q     = int'(v);
    chk("load_q", q, m_q);
    chk("load_so", so, m_so);
    chk("load_busy", busy, 0);
  endtask

  // en_mode: 0 en always 1, 1 random en plus garbage on ignored inputs,
  // 2 en alternating 1,0,1,... ; dsel: 0/1 fixed d, 2 random d.
  task automatic run_cmd(input int o, input int amt, input int en_mode, input int dsel);
    int rem;
    int it;
    int dv;
    op      = o[2:0];
    amount  = amt[AW-1:0];
    start   = 1'b1;
    load_en = 1'b0;
    en      = 1'b1;
    tick();
    start = 1'b0;
    chk("accept_busy", busy, (amt > 0) ? 1 : 0);
    chk("accept_done", done, (amt == 0) ? 1 : 0);
    chk("accept_q", q, m_q);
    rem = amt;
    it  = 0;
    while (rem > 0) begin
      case (en_mode)
        1:       en = (it > 40) ? 1'b1 : 1'($urandom_range(0, 1));
        2:       en = (it % 2 == 0);
        default: en = 1'b1;
      endcase
      dv = (dsel == 2) ? int'($urandom_range(0, 1)) : dsel;
      d  = dv[0];
      if (en_mode == 1) begin
        op      = 3'($urandom);
        amount  = AW'($urandom);
        start   = 1'($urandom);
        load_en = 1'($urandom);
        load    = N'($urandom);
      end
      tick();
      if (en) begin
        model_pos(o, dv);
        rem--;
      end
      chk("step_q", q, m_q);
      chk("step_so", so, m_so);
      chk("step_busy", busy, (rem > 0) ? 1 : 0);
      chk("step_done", done, (rem == 0) ? 1 : 0);
      it++;
    end
    start   = 1'b0;
    load_en = 1'b0;
    en      = 1'b1;
    tick();
    chk("done_clear", done, 0);
    chk("idle_busy", busy, 0);
    chk("idle_q", q, m_q);
    $display("cmd op=%0d amount=%0d cycles=%0d q=%02h so=%0d", o, amt, it, q, so);
  endtask

  initial begin
    reset   = 1'b1;
    load    = '0;
    load_en = 1'b0;
    start   = 1'b0;
    op      = '0;
    amount  = '0;
    d       = 1'b0;
    en      = 1'b0;
    tick();
    tick();
    m_q  = FULL - 1;
    m_so = 0;
    chk("reset_q", q, 8'hFF);
    chk("reset_so", so, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    reset = 1'b0;

    // SLL by 3 with d=1
    do_load(8'hB4);
    run_cmd(0, 3, 0, 1);
    chk("t2_q", q, 8'hA7);
    chk("t2_so", so, 1);

    // SRA by 2 with en stalled for one cycle
    do_load(8'h96);
    run_cmd(2, 2, 2, 0);
    chk("t3_q", q, 8'hE5);

    // ROR by 9 wraps to one rotate; amount 0 completes immediately
    do_load(8'h81);
    run_cmd(4, 9, 0, 0);
    chk("t4_q", q, 8'hC0);
    chk("t4_so", so, 1);
    run_cmd(4, 0, 0, 0);
    chk("t4_zero_q", q, 8'hC0);

    // start/load_en ignored mid-command, then reset aborts
    do_load(8'h3C);
    op     = 3'd0;
    amount = 4'd5;
    start  = 1'b1;
    d      = 1'b0;
    en     = 1'b1;
    tick();
    chk("t5_busy0", busy, 1);
    load    = 8'h00;
    load_en = 1'b1;
    start   = 1'b1;
    amount  = 4'd0;
    tick();
    model_pos(0, 0);
    chk("t5_q", q, m_q);
    chk("t5_busy1", busy, 1);
    load_en = 1'b0;
    start   = 1'b0;
    reset   = 1'b1;
    tick();
    reset = 1'b0;
    m_q   = FULL - 1;
    m_so  = 0;
    chk("t5_rst_q", q, 8'hFF);
    chk("t5_rst_so", so, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_done", done, 0);
    tick();
    chk("t5_after_done", done, 0);
    chk("t5_after_busy", busy, 0);
    $display("cmd reset-abort q=%02h busy=%0d", q, busy);

    // load_en and start together: load wins, no command
    load    = 8'h5A;
    load_en = 1'b1;
    start   = 1'b1;
    amount  = 4'd3;
    op      = 3'd0;
    tick();
    load_en = 1'b0;
    start   = 1'b0;
    m_q     = 'h5A;
    chk("t6_q", q, 8'h5A);
    chk("t6_busy", busy, 0);
    chk("t6_done", done, 0);
    tick();
    chk("t6_done2", done, 0);
    chk("t6_busy2", busy, 0);
    $display("cmd load+start q=%02h busy=%0d done=%0d", q, busy, done);

    // random commands, including reserved ops and amount > width
    for (int i = 0; i < 25; i++) begin
      if ($urandom_range(0, 1) == 1) do_load(N'($urandom));
      run_cmd(int'($urandom_range(0, 7)), int'($urandom_range(0, 15)), 1, 2);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
